// File: rtl/leaf_port_arbiter_if.sv
// Handshake bundle between requesters, the shared leaf datapath and the response consumer.
// master = environment side (requesters, leaf, consumer); slave = leaf_port_arbiter.
interface leaf_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         leaf_inn;
  logic [DATA_W-1:0]         leaf_out;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_ready;
  logic                      busy;

  modport master (
    output req_valid,
    output req_data,
    output leaf_out,
    output rsp_ready,
    input  req_ready,
    input  leaf_inn,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  leaf_out,
    input  rsp_ready,
    output req_ready,
    output leaf_inn,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    output busy
  );
endinterface

// File: rtl/leaf_port_arbiter.sv
// Round-robin share of one combinational leaf among NUM_REQ requesters; 3+ cycles per op,
// response held until rsp_ready. `define ARB_PERF_CNT_EN adds xfer_cnt/stall_cnt.
module leaf_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  leaf_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [DATA_W-1:0]   leaf_inn_q, leaf_inn_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic [NUM_REQ-1:0]  grant;
  logic                rsp_hs;

  assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

  // Search starts just after the last served requester, so it gets lowest priority next.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    leaf_inn_d  = leaf_inn_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    grant       = '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant[win_id] = 1'b1;
          leaf_inn_d    = bus.req_data[int'(win_id)*DATA_W +: DATA_W];
          gnt_id_d      = win_id;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d  = bus.leaf_out;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = gnt_id_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      leaf_inn_q  <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      leaf_inn_q  <= leaf_inn_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Accept strobe is combinational, so it is masked while reset is asserted.
  assign bus.req_ready = grant & {NUM_REQ{rst_n}};
  assign bus.leaf_inn  = leaf_inn_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rsp_hs && (xfer_cnt_q != '1)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
    if ((state_q == RESP) && !bus.rsp_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_leaf_port_arbiter.sv
// Directed self-checking bench for leaf_port_arbiter (4 requesters, 3-bit leaf, CNT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_leaf_port_arbiter;
  logic clk;
  logic rst_n;
  logic [2:0] leaf_xor;
  int total;
  int bad;

  leaf_port_arbiter_if #(.NUM_REQ(4), .DATA_W(3)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [3:0] xfer_cnt;
  logic [3:0] stall_cnt;
`endif

  leaf_port_arbiter #(.NUM_REQ(4), .DATA_W(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Leaf model: combinational XOR mask (identity when leaf_xor = 0)
  assign bus.leaf_out = bus.leaf_inn ^ leaf_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_data(input int i, input logic [2:0] d);
    bus.req_data[i*3 +: 3] = d;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    leaf_xor      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    set_data(0, 3'b110);
    set_data(1, 3'b011);
    set_data(2, 3'b001);
    bus.req_valid = 4'b0111;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'b110) begin
      bad++; $display("FAIL reset_pre_resp: got v=%b d=%0d want v=1 d=6", bus.rsp_valid, bus.rsp_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000 || bus.leaf_inn !== 3'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_async_ctl: got rdy=%b inn=%0d busy=%b want 0/0/0",
                      bus.req_ready, bus.leaf_inn, bus.busy);
    end
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 3'd0 || bus.rsp_id !== 2'd0) begin
      bad++; $display("FAIL reset_async_rsp: got v=%b d=%0d id=%0d want 0/0/0",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b rdy=%b v=%b want 0/0000/0",
                      bus.busy, bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_data(2, 3'b101);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    total++;
    if (bus.leaf_inn !== 3'd5 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL single_issue: got inn=%0d busy=%b rdy=%b want 5/1/0000",
                      bus.leaf_inn, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd5 || bus.rsp_id !== 2'd2) begin
      bad++; $display("FAIL single_resp: got v=%b d=%0d id=%0d want 1/5/2",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.leaf_inn !== 3'd5) begin
      bad++; $display("FAIL single_done: got v=%b busy=%b inn=%0d want 0/0/5",
                      bus.rsp_valid, bus.busy, bus.leaf_inn);
    end
  endtask

  task automatic test_round_robin();
    int ids[5];
    int dats[5];
    int cyc[5];
    int n;
    int exp_id[5];
    exp_id = '{0, 1, 2, 3, 0};
    n = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) set_data(i, 3'(2*i + 1));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        ids[n]  = int'(bus.rsp_id);
        dats[n] = int'(bus.rsp_data);
        cyc[n]  = c;
        n++;
      end
    end
    bus.req_valid = '0;
    total++;
    if (n != 5) begin
      bad++; $display("FAIL rr_timeout: got %0d responses want 5", n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (ids[k] != exp_id[k] || dats[k] != 2*exp_id[k] + 1) begin
          bad++; $display("FAIL rr_rsp%0d: got id=%0d d=%0d want id=%0d d=%0d",
                          k, ids[k], dats[k], exp_id[k], 2*exp_id[k] + 1);
        end
        if (k > 0) begin
          total++;
          if (cyc[k] - cyc[k-1] != 3) begin
            bad++; $display("FAIL rr_gap%0d: got %0d cycles want 3", k, cyc[k] - cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_data(1, 3'b110);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_data(3, 3'b010);
    bus.req_valid = 4'b1010;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd6 || bus.rsp_id !== 2'd1 ||
          bus.req_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b d=%0d id=%0d rdy=%b want 1/6/1/0000",
                        s, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      end
    end
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    total++;
    if (stall_cnt !== 4'd5 || xfer_cnt !== 4'd0) begin
      bad++; $display("FAIL stall_cnt: got stall=%0d xfer=%0d want 5/0", stall_cnt, xfer_cnt);
    end
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b1000) begin
      bad++; $display("FAIL stall_release: got v=%b busy=%b rdy=%b want 0/0/1000",
                      bus.rsp_valid, bus.busy, bus.req_ready);
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (xfer_cnt !== 4'd1 || stall_cnt !== 4'd5) begin
      bad++; $display("FAIL stall_xfer: got xfer=%0d stall=%0d want 1/5", xfer_cnt, stall_cnt);
    end
`endif
    bus.req_valid = '0;
  endtask

  task automatic test_reset_in_issue();
    int got;
    apply_reset();
    set_data(0, 3'b100);
    set_data(1, 3'b010);
    set_data(2, 3'b011);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    total++;
    if (bus.busy !== 1'b1 || bus.leaf_inn !== 3'd3) begin
      bad++; $display("FAIL drop_issue: got busy=%b inn=%0d want 1/3", bus.busy, bus.leaf_inn);
    end
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus.req_valid = 4'b0111;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1;
        total++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 3'd4) begin
          bad++; $display("FAIL drop_first_rsp: got id=%0d d=%0d want 0/4", bus.rsp_id, bus.rsp_data);
        end
      end
    end
    bus.req_valid = '0;
    if (got == 0) begin
      total++;
      bad++; $display("FAIL drop_timeout: got no response want one");
    end
  endtask

  task automatic test_leaf_xform();
    apply_reset();
    leaf_xor = 3'b110;
    set_data(3, 3'b011);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) begin
      bad++; $display("FAIL xform_ready: got %b want 1000", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus.rsp_data !== 3'b101 || bus.rsp_id !== 2'd3 || bus.leaf_inn !== 3'b011) begin
      bad++; $display("FAIL xform_resp: got d=%b id=%0d inn=%b want 101/3/011",
                      bus.rsp_data, bus.rsp_id, bus.leaf_inn);
    end
    @(negedge clk);
    total++;
    if (bus.leaf_inn !== 3'b011 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL xform_idle: got inn=%b v=%b want 011/0", bus.leaf_inn, bus.rsp_valid);
    end
    leaf_xor = '0;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_saturate();
    int hs;
    hs = 0;
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 100 && hs < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) hs++;
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (hs != 20 || xfer_cnt !== 4'd15 || stall_cnt !== 4'd0) begin
      bad++; $display("FAIL sat_cnt: got hs=%0d xfer=%0d stall=%0d want 20/15/0", hs, xfer_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    leaf_xor      = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_in_issue();
    test_leaf_xform();
`ifdef ARB_PERF_CNT_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
